// File: rtl/serial_pattern_monitor_pkg.sv
// Shared types and default parameters for the serial pattern monitor.
// The state type distinguishes filling the shift register from matching.
package pattern_mon_pkg;

  typedef enum logic {
    FILL,
    RUN
  } mon_state_t;

  localparam int unsigned DefaultPatW    = 4;
  localparam logic [3:0]  DefaultPattern = 4'b1011;
  localparam int unsigned DefaultCntW    = 8;

endpackage

// File: rtl/serial_pattern_monitor_if.sv
// Bit-stream input and status outputs of the serial pattern monitor.
// The master drives the stream; the slave (the monitor) reports match status.
interface serial_pattern_monitor_if
  import pattern_mon_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
);

  logic             y;
  logic             y_en;
  logic             clear;
  logic             filled;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] gap;
  logic             gap_valid;

  modport master (
    output y,
    output y_en,
    output clear,
    input  filled,
    input  match,
    input  match_count,
    input  gap,
    input  gap_valid
  );

  modport slave (
    input  y,
    input  y_en,
    input  clear,
    output filled,
    output match,
    output match_count,
    output gap,
    output gap_valid
  );

endinterface

// File: rtl/serial_pattern_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Max = {W{1'b1}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != Max)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_pattern_monitor.sv
// Detects PATTERN (overlapping) in a qualified serial bit stream, counts matches and
// measures the sample distance between consecutive matches.
module serial_pattern_monitor
  import pattern_mon_pkg::*;
#(
  parameter int unsigned       PAT_W   = DefaultPatW,
  parameter logic [PAT_W-1:0]  PATTERN = DefaultPattern,
  parameter int unsigned       CNT_W   = DefaultCntW
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_pattern_monitor_if.slave  mon
);

  localparam int unsigned      FillW    = $clog2(PAT_W);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  mon_state_t       state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [PAT_W-1:0] sr_next;
  logic             have_prev_q, have_prev_d;
  logic             match_q;
  logic             gap_valid_q, gap_valid_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] dist_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic             sample;
  logic             hit;
  logic             dist_inc;
  logic             dist_clr;

  assign sample  = mon.y_en && !mon.clear;
  assign sr_next = {sr_q[PAT_W-2:0], mon.y};

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    sr_d        = sr_q;
    have_prev_d = have_prev_q;
    gap_d       = gap_q;
    gap_valid_d = 1'b0;
    hit         = 1'b0;

    if (mon.clear) begin
      state_d     = FILL;
      fill_d      = '0;
      sr_d        = '0;
      have_prev_d = 1'b0;
      gap_d       = '0;
    end else if (mon.y_en) begin
      sr_d = sr_next;
      unique case (state_q)
        FILL: begin
          // The PAT_W-th sample completes a full window, so it may already match.
          if (fill_q == FillLast) begin
            state_d = RUN;
            hit     = (sr_next == PATTERN);
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        RUN: begin
          hit = (sr_next == PATTERN);
        end
        default: begin
          state_d = FILL;
        end
      endcase

      if (hit) begin
        have_prev_d = 1'b1;
        if (have_prev_q) begin
          // dist_q counts samples strictly between the two completing bits.
          gap_d       = (dist_q == CntMax) ? CntMax : dist_q + 1'b1;
          gap_valid_d = 1'b1;
        end
      end
    end
  end

  assign dist_inc = sample && have_prev_q && !hit;
  assign dist_clr = mon.clear || hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FILL;
      fill_q      <= '0;
      sr_q        <= '0;
      have_prev_q <= 1'b0;
      match_q     <= 1'b0;
      gap_valid_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      sr_q        <= sr_d;
      have_prev_q <= have_prev_d;
      match_q     <= hit;
      gap_valid_q <= gap_valid_d;
      gap_q       <= gap_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (mon.clear),
    .q     (match_cnt_q)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_dist_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (dist_inc),
    .clr   (dist_clr),
    .q     (dist_q)
  );

  assign mon.filled      = (state_q == RUN);
  assign mon.match       = match_q;
  assign mon.match_count = match_cnt_q;
  assign mon.gap         = gap_q;
  assign mon.gap_valid   = gap_valid_q;

endmodule

// File: tb/tb_serial_pattern_monitor.sv
// Directed bench for serial_pattern_monitor: a default-width instance and a
// CNT_W=3 instance share one stimulus stream.
module tb_serial_pattern_monitor;

  logic clk;
  logic rst_n;
  logic y;
  logic y_en;
  logic clear;

  int vectors = 0;
  int errors  = 0;

  serial_pattern_monitor_if #(.CNT_W(8)) ifa ();
  serial_pattern_monitor_if #(.CNT_W(3)) ifb ();

  assign ifa.y     = y;
  assign ifa.y_en  = y_en;
  assign ifa.clear = clear;
  assign ifb.y     = y;
  assign ifb.y_en  = y_en;
  assign ifb.clear = clear;

  serial_pattern_monitor #(
    .PAT_W   (4),
    .PATTERN (4'b1011),
    .CNT_W   (8)
  ) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .mon   (ifa.slave)
  );

  serial_pattern_monitor #(
    .PAT_W   (4),
    .PATTERN (4'b1011),
    .CNT_W   (3)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .mon   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, return at the next falling edge.
  task automatic step(input logic yv, input logic env, input logic clr);
    y     = yv;
    y_en  = env;
    clear = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    y     = 1'b0;
    y_en  = 1'b0;
    clear = 1'b0;

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    chk("rst_filled", 32'(ifa.filled), 0);
    chk("rst_match", 32'(ifa.match), 0);
    chk("rst_count", 32'(ifa.match_count), 0);
    chk("rst_gap", 32'(ifa.gap), 0);
    chk("rst_gap_valid", 32'(ifa.gap_valid), 0);
    rst_n = 1'b1;

    // First match exactly on the filling sample
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t1_filled_early", 32'(ifa.filled), 0);
    chk("t1_match_early", 32'(ifa.match), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t1_filled", 32'(ifa.filled), 1);
    chk("t1_match", 32'(ifa.match), 1);
    chk("t1_count", 32'(ifa.match_count), 1);
    chk("t1_gap_valid", 32'(ifa.gap_valid), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_match_pulse", 32'(ifa.match), 0);

    // Overlapping matches, gap of 3
    step(1'b0, 1'b0, 1'b1);
    chk("t2_clr_count", 32'(ifa.match_count), 0);
    chk("t2_clr_filled", 32'(ifa.filled), 0);
    feed4(4'b1011);
    chk("t2_m1", 32'(ifa.match), 1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_nomatch6", 32'(ifa.match), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t2_m2", 32'(ifa.match), 1);
    chk("t2_gap", 32'(ifa.gap), 3);
    chk("t2_gap_valid", 32'(ifa.gap_valid), 1);
    chk("t2_count", 32'(ifa.match_count), 2);
    step(1'b0, 1'b0, 1'b0);
    chk("t2_gap_valid_pulse", 32'(ifa.gap_valid), 0);
    chk("t2_gap_hold", 32'(ifa.gap), 3);
    chk("t2_count_hold", 32'(ifa.match_count), 2);

    // y_en low freezes state
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("t3_idle_match", 32'(ifa.match), 0);
      chk("t3_idle_filled", 32'(ifa.filled), 0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("t3_match", 32'(ifa.match), 1);
    chk("t3_count", 32'(ifa.match_count), 1);
    chk("t3_filled", 32'(ifa.filled), 1);

    // Saturation of the 3-bit counter
    step(1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      feed4(4'b1011);
      chk("t4_b_match", 32'(ifb.match), 1);
      chk("t4_b_count", 32'(ifb.match_count), (k > 7) ? 7 : k);
      chk("t4_a_count", 32'(ifa.match_count), k);
    end
    chk("t4_b_gap", 32'(ifb.gap), 4);
    chk("t4_b_gap_valid", 32'(ifb.gap_valid), 1);

    // Clear discards the simultaneous sample
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5_match", 32'(ifa.match), 0);
    chk("t5_filled", 32'(ifa.filled), 0);
    chk("t5_count", 32'(ifa.match_count), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("t5_s1", 32'(ifa.match), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_s2", 32'(ifa.match), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_s3", 32'(ifa.match), 0);
    chk("t5_s3_filled", 32'(ifa.filled), 0);

    // Asynchronous reset between edges
    step(1'b0, 1'b0, 1'b1);
    feed4(4'b1011);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6_pre_count", 32'(ifa.match_count), 2);
    chk("t6_pre_gap", 32'(ifa.gap), 3);
    y = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(ifa.match_count), 0);
    chk("t6_async_gap", 32'(ifa.gap), 0);
    chk("t6_async_filled", 32'(ifa.filled), 0);
    chk("t6_async_match", 32'(ifa.match), 0);
    chk("t6_async_gap_valid", 32'(ifa.gap_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed4(4'b1011);
    chk("t6_match", 32'(ifa.match), 1);
    chk("t6_count", 32'(ifa.match_count), 1);
    chk("t6_gap_valid", 32'(ifa.gap_valid), 0);
    chk("t6_gap", 32'(ifa.gap), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("t6_single", 32'(ifa.match), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
